// File: rtl/dec_sel_sequencer.sv
// dec_sel_sequencer
// Round-robin channel-select sequencer that drives the {en, in[2:0]} inputs of
// a 3-to-8 decoder. A start command captures a request mask and a dwell value.
// Each requested channel is then granted in round-robin order. Every grant
// holds the decoder enabled for dwell+1 cycles, and a break-before-make gap
// separates consecutive grants. A one-cycle done pulse closes the burst.
//
// Handshake: start is a single-cycle command. It is accepted only while the
// FSM is IDLE (busy low), which includes the cycle in which done is high.
// req and dwell are sampled only on that accepting edge. done is a one-cycle
// completion pulse with no back-pressure.

module dec_sel_sequencer #(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [7:0]         req,
   input  logic [DWELL_W-1:0] dwell,
   output logic [2:0]         sel,
   output logic               en,
   output logic               busy,
   output logic               done,
   output logic [1:0]         state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      HOLD = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t             state;
   logic [7:0]         pend;
   logic [2:0]         ptr;
   logic [DWELL_W-1:0] dw;
   logic [DWELL_W-1:0] cnt;
   logic [2:0]         grant;
   logic               found;
   logic [2:0]         idx;

   // Round-robin search: first pending channel at or after ptr, wrapping mod 8
   always_comb begin
      grant = ptr;
      found = 1'b0;
      idx   = ptr;
      for (int o = 0; o < 8; o++) begin
         idx = ptr + 3'(o);
         if (!found && pend[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   // Sequencer FSM with registered decoder outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         sel   <= 3'd0;
         en    <= 1'b0;
         done  <= 1'b0;
         pend  <= 8'h00;
         dw    <= '0;
         cnt   <= '0;
         ptr   <= 3'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (req != 8'h00) begin
                     pend  <= req;
                     dw    <= dwell;
                     state <= ARB;
                  end else begin
                     // Empty request: finish immediately without going busy
                     done <= 1'b1;
                  end
               end
            end
            ARB: begin
               sel         <= grant;
               pend[grant] <= 1'b0;
               ptr         <= grant + 3'd1;
               cnt         <= dw;
               en          <= 1'b1;
               state       <= HOLD;
            end
            HOLD: begin
               if (cnt == '0) begin
                  en    <= 1'b0;
                  state <= GAP;
               end else begin
                  cnt <= cnt - DWELL_W'(1);
               end
            end
            GAP: begin
               if (pend != 8'h00) begin
                  state <= ARB;
               end else begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule
